// File: rtl/ym_pkg.sv
// rtl/ym_pkg.sv - shared types and constants for the YM2610 PCM block
package ym_pkg;

  localparam int PCMA_NCH    = 6;
  localparam int PCMA_ADDR_W = 22;

  typedef enum logic [2:0] {
    IDLE,
    LATCH_L,
    LATCH_H,
    OE,
    CAPTURE
  } pcma_state_e;

  function automatic logic [PCMA_NCH-1:0] ch_onehot(input logic [2:0] id);
    return {{(PCMA_NCH-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage

// File: rtl/ym_rr_arb6.sv
// rtl/ym_rr_arb6.sv - 6-way round-robin picker, search starts one past the last grant
module ym_rr_arb6
  import ym_pkg::*;
(
  input  logic [PCMA_NCH-1:0] req_i,
  input  logic [2:0]          last_i,
  output logic                valid_o,
  output logic [2:0]          id_o
);

  int         idx;
  logic [2:0] idx3;

  // Walk from the farthest candidate to the nearest so the nearest match wins.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    idx     = 0;
    idx3    = '0;
    for (int k = PCMA_NCH; k >= 1; k--) begin
      idx = int'(last_i) + k;
      if (idx >= PCMA_NCH) idx = idx - PCMA_NCH;
      idx3 = 3'(idx);
      if (req_i[idx3]) begin
        valid_o = 1'b1;
        id_o    = idx3;
      end
    end
  end

endmodule

// File: rtl/ym_pcma_rom_sched.sv
// rtl/ym_pcma_rom_sched.sv - ADPCM-A sample ROM bus scheduler for six channel fetchers
module ym_pcma_rom_sched
  import ym_pkg::*;
#(
  parameter int OE_CYCLES = 3,
  parameter int NCH       = 6
) (
  input  logic                       PHI_M,
  input  logic                       RESET,
  input  logic [NCH-1:0]             REQ,
  input  logic [NCH*PCMA_ADDR_W-1:0] REQ_ADDR,
  output logic [NCH-1:0]             ACK,
  output logic [7:0]                 ROM_DATA,
  output logic [2:0]                 GRANT_ID,
  output logic                       BUSY,
  inout  wire  [7:0]                 SDRAD,
  output logic [5:0]                 SDRA,
  output logic                       SDRMPX,
  output logic                       nSDROE
);

  localparam logic [3:0] OE_LOAD = 4'(OE_CYCLES - 1);

  pcma_state_e      state_q;
  logic [2:0]       grant_q;
  logic [2:0]       rr_q;
  logic [7:0]       addr_hi_q;
  logic [7:0]       sdrad_out_q;
  logic             sdrad_en_q;
  logic [5:0]       sdra_q;
  logic             sdrmpx_q;
  logic             nsdroe_q;
  logic [7:0]       rom_data_q;
  logic [NCH-1:0]   ack_q;
  logic [3:0]       oe_cnt_q;

  logic [NCH-1:0]         arb_req_d;
  logic                   arb_valid;
  logic [2:0]             arb_id;
  logic [PCMA_ADDR_W-1:0] sel_addr_d;
  logic                   start_d;

  // Whoever is being (or about to be) acknowledged still holds REQ; keep it out.
  always_comb begin
    arb_req_d = REQ & ~ack_q;
    if (state_q == CAPTURE) arb_req_d = arb_req_d & ~ch_onehot(grant_q);
  end

  ym_rr_arb6 u_arb (
    .req_i   (arb_req_d),
    .last_i  (rr_q),
    .valid_o (arb_valid),
    .id_o    (arb_id)
  );

  always_comb begin
    sel_addr_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (arb_id == 3'(i)) sel_addr_d = REQ_ADDR[i*PCMA_ADDR_W +: PCMA_ADDR_W];
    end
  end

  assign start_d = arb_valid && (state_q == IDLE || state_q == CAPTURE);

  always_ff @(posedge PHI_M or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      addr_hi_q   <= '0;
      sdrad_out_q <= '0;
      sdrad_en_q  <= 1'b0;
      sdra_q      <= '0;
      sdrmpx_q    <= 1'b0;
      nsdroe_q    <= 1'b1;
      rom_data_q  <= '0;
      ack_q       <= '0;
      oe_cnt_q    <= '0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        IDLE: ;
        LATCH_L: begin
          state_q     <= LATCH_H;
          sdrad_out_q <= addr_hi_q;
          sdrmpx_q    <= 1'b0;
        end
        LATCH_H: begin
          state_q    <= OE;
          sdrad_en_q <= 1'b0;
          nsdroe_q   <= 1'b0;
          oe_cnt_q   <= OE_LOAD;
        end
        OE: begin
          if (oe_cnt_q == 4'd0) state_q <= CAPTURE;
          else                  oe_cnt_q <= oe_cnt_q - 4'd1;
        end
        CAPTURE: begin
          rom_data_q <= SDRAD;
          ack_q      <= ch_onehot(grant_q);
          nsdroe_q   <= 1'b1;
          state_q    <= IDLE;
          sdra_q     <= '0;
        end
        default: state_q <= IDLE;
      endcase

      // A new grant overrides the IDLE/CAPTURE defaults above, giving back-to-back accesses.
      if (start_d) begin
        state_q     <= LATCH_L;
        grant_q     <= arb_id;
        rr_q        <= arb_id;
        addr_hi_q   <= sel_addr_d[15:8];
        sdrad_out_q <= sel_addr_d[7:0];
        sdrad_en_q  <= 1'b1;
        sdra_q      <= sel_addr_d[21:16];
        sdrmpx_q    <= 1'b1;
      end
    end
  end

  assign SDRAD    = sdrad_en_q ? sdrad_out_q : 8'bzzzz_zzzz;
  assign SDRA     = sdra_q;
  assign SDRMPX   = sdrmpx_q;
  assign nSDROE   = nsdroe_q;
  assign ACK      = ack_q;
  assign ROM_DATA = rom_data_q;
  assign GRANT_ID = grant_q;
  assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_ym_pcma_rom_sched.sv
// tb/tb_ym_pcma_rom_sched.sv - directed bench for the ADPCM-A ROM scheduler
module tb_ym_pcma_rom_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [5:0]   req = '0;
  logic [131:0] req_addr = '0;
  logic [5:0]   ack;
  logic [7:0]   rom_data;
  logic [2:0]   grant_id;
  logic         busy;
  wire  [7:0]   sdrad;
  logic [5:0]   sdra;
  logic         sdrmpx;
  logic         nsdroe;

  logic [7:0]   rom_byte = 8'hA5;
  logic [7:0]   lat_lo = '0;
  logic [7:0]   lat_hi = '0;
  logic [5:0]   lat_a = '0;
  logic         mpx_prev = 1'b0;

  int errors = 0;
  int checks = 0;
  int ack_id[8];
  int ack_t[8];

  always #5 clk = ~clk;

  ym_pcma_rom_sched #(.OE_CYCLES(3), .NCH(6)) dut (
    .PHI_M    (clk),
    .RESET    (rst),
    .REQ      (req),
    .REQ_ADDR (req_addr),
    .ACK      (ack),
    .ROM_DATA (rom_data),
    .GRANT_ID (grant_id),
    .BUSY     (busy),
    .SDRAD    (sdrad),
    .SDRA     (sdra),
    .SDRMPX   (sdrmpx),
    .nSDROE   (nsdroe)
  );

  // ROM model: drives the bus only while output enable is asserted
  assign sdrad = (nsdroe === 1'b0) ? rom_byte : 8'bzzzz_zzzz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sdrmpx === 1'b1) begin
      lat_lo = sdrad;
      lat_a  = sdra;
    end
    if (mpx_prev === 1'b1 && sdrmpx === 1'b0) lat_hi = sdrad;
    mpx_prev = sdrmpx;
    if (rst === 1'b0 && nsdroe === 1'b0) chk("bus_contention", 32'(sdrad), 32'(rom_byte));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  function automatic int ack2id(input logic [5:0] a);
    for (int i = 0; i < 6; i++) if (a[i]) return i;
    return -1;
  endfunction

  task automatic collect(input int n, input int budget);
    int cnt;
    cnt = 0;
    for (int t = 1; t <= budget && cnt < n; t++) begin
      tick(1);
      if (ack !== 6'b0) begin
        chk("ack_onehot", 32'($onehot(ack)), 1);
        ack_id[cnt] = ack2id(ack);
        ack_t[cnt]  = t;
        cnt++;
      end
    end
    chk("ack_count", 32'(cnt), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while ((busy !== 1'b0 || ack !== 6'b0) && t < budget) begin
      tick(1);
      t++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    int ack_at;
    int exp_all[7];
    int exp_alt[4];
    int n_ack;
    exp_all = '{1, 2, 3, 4, 5, 0, 1};
    exp_alt = '{5, 0, 5, 0};

    // reset values and quiet idle
    tick(2);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_nsdroe", 32'(nsdroe), 1);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick(4);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_nsdroe", 32'(nsdroe), 1);
    chk("idle_sdrmpx", 32'(sdrmpx), 0);
    chk("idle_sdra", 32'(sdra), 0);
    chk("idle_rom_data", 32'(rom_data), 0);
    chk("idle_grant", 32'(grant_id), 0);

    // single access, channel 2
    rom_byte = 8'hA5;
    req_addr[2*22 +: 22] = 22'h123456;
    req = 6'b000100;
    tick(1);
    chk("t1_latl_sdrad", 32'(sdrad), 32'h56);
    chk("t1_latl_mpx", 32'(sdrmpx), 1);
    chk("t1_latl_sdra", 32'(sdra), 32'h12);
    chk("t1_grant", 32'(grant_id), 2);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_latl_oe", 32'(nsdroe), 1);
    tick(1);
    chk("t1_lath_sdrad", 32'(sdrad), 32'h34);
    chk("t1_lath_mpx", 32'(sdrmpx), 0);
    low = 0;
    ack_at = -1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (nsdroe === 1'b0) low++;
      if (ack !== 6'b0 && ack_at < 0) begin
        ack_at = i + 3;
        chk("t1_ack_val", 32'(ack), 32'(6'b000100));
        chk("t1_rom_data", 32'(rom_data), 32'hA5);
        chk("t1_oe_release", 32'(nsdroe), 1);
      end
    end
    req = '0;
    chk("t1_oe_cycles", 32'(low), 4);
    chk("t1_latency", 32'(ack_at), 7);
    chk("t1_rom_addr", 32'({lat_a, lat_hi, lat_lo}), 32'h123456);
    tick(1);
    chk("t1_after_busy", 32'(busy), 0);
    chk("t1_after_ack", 32'(ack), 0);

    // all channels requesting
    do_reset();
    req = 6'b111111;
    collect(7, 60);
    req = '0;
    for (int i = 0; i < 7; i++) chk($sformatf("t2_order%0d", i), 32'(ack_id[i]), 32'(exp_all[i]));
    for (int i = 1; i < 7; i++) chk($sformatf("t2_gap%0d", i), 32'(ack_t[i] - ack_t[i-1]), 6);
    wait_idle(20);

    // channels 5 and 0 alternate across the pointer wrap
    do_reset();
    req = 6'b100001;
    collect(4, 40);
    req = '0;
    for (int i = 0; i < 4; i++) chk($sformatf("t3_order%0d", i), 32'(ack_id[i]), 32'(exp_alt[i]));
    chk("t3_gap", 32'(ack_t[1] - ack_t[0]), 6);
    wait_idle(20);

    // reset in the middle of an OE phase
    do_reset();
    req_addr[3*22 +: 22] = 22'h000300;
    req = 6'b001000;
    tick(3);
    chk("t4_in_oe", 32'(nsdroe), 0);
    chk("t4_grant", 32'(grant_id), 3);
    rst = 1'b1;
    req = '0;
    #1;
    chk("t4_rst_nsdroe", 32'(nsdroe), 1);
    chk("t4_rst_busy", 32'(busy), 0);
    chk("t4_rst_sdrmpx", 32'(sdrmpx), 0);
    tick(2);
    rst = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (ack !== 6'b0) n_ack++;
    end
    chk("t4_no_ack", 32'(n_ack), 0);
    req = 6'b111111;
    tick(1);
    chk("t4_rr_restart", 32'(grant_id), 1);
    req = '0;
    wait_idle(20);

    // REQ dropped and address changed after grant
    rom_byte = 8'h3C;
    req_addr[4*22 +: 22] = 22'h2ABCDE;
    req = 6'b010000;
    tick(1);
    chk("t5_grant", 32'(grant_id), 4);
    chk("t5_latl_sdrad", 32'(sdrad), 32'hDE);
    chk("t5_latl_sdra", 32'(sdra), 32'h2A);
    tick(1);
    chk("t5_lath_sdrad", 32'(sdrad), 32'hBC);
    req = '0;
    req_addr[4*22 +: 22] = 22'h011111;
    collect(1, 12);
    chk("t5_ack_id", 32'(ack_id[0]), 4);
    chk("t5_ack_time", 32'(ack_t[0]), 5);
    chk("t5_rom_data", 32'(rom_data), 32'h3C);
    chk("t5_rom_addr", 32'({lat_a, lat_hi, lat_lo}), 32'h2ABCDE);
    wait_idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
